// File: rtl/div_32bit.sv
// div_32bit -- unsigned 32/16 divider with one cycle of latency.
//
// A combinational 32-row restoring-division array produces the quotient and
// remainder from A and B. They are captured into output registers on any
// rising clk edge where in_valid is high. A new operand pair can be accepted
// every cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   A/B valid this cycle; capture request
//   A          32-bit unsigned dividend
//   B          16-bit unsigned divisor
//   result     registered quotient floor(A/B); 32'hFFFFFFFF when B == 0
//   odd        registered remainder A mod B, zero-extended; A when B == 0
//   out_valid  high for one cycle after each capture
module div_32bit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [31:0] A,
   input  logic [15:0] B,
   output logic [31:0] result,
   output logic [31:0] odd,
   output logic        out_valid
);

   logic [31:0] quo_comb;
   logic [31:0] rem_comb;

   // Restoring array, processed MSB first. Each row shifts in one dividend
   // bit and subtracts the divisor when it fits. When B != 0, the partial
   // remainder is always below B after each row, so 17 bits are enough.
   // Its top bit is zero at the end.
   // Divide by zero would lose dividend bits as they shift out of the 17-bit
   // partial remainder. For that reason, that case is forced explicitly.
   always_comb begin
      logic [16:0] r;
      logic [16:0] b_ext;
      quo_comb = '0;
      rem_comb = '0;
      r        = '0;
      b_ext    = {1'b0, B};
      for (int i = 31; i >= 0; i--) begin
         r = {r[15:0], A[i]};
         if (r >= b_ext) begin
            quo_comb[i] = 1'b1;
            r           = r - b_ext;
         end
      end
      if (B == 16'd0) begin
         quo_comb = 32'hFFFF_FFFF;
         rem_comb = A;
      end else begin
         rem_comb = {15'd0, r};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result    <= '0;
         odd       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            result <= quo_comb;
            odd    <= rem_comb;
         end
      end
   end

endmodule

// File: tb/tb_div_32bit.sv
// tb_div_32bit -- directed and random checks of div_32bit.
// Inputs change on the falling edge. Outputs are sampled 1 ns after the rising edge.
module tb_div_32bit;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] A;
   logic [15:0] B;
   logic [31:0] result;
   logic [31:0] odd;
   logic        out_valid;

   int n_checks = 0;
   int n_pass   = 0;

   div_32bit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .A         (A),
      .B         (B),
      .result    (result),
      .odd       (odd),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
   endtask

   // Apply one operand pair with in_valid high, then check the captured result.
   task automatic div_op(input string tag, input logic [31:0] a, input logic [15:0] b,
                         input logic [31:0] exp_q, input logic [31:0] exp_r);
      @(negedge clk);
      in_valid = 1'b1;
      A        = a;
      B        = b;
      @(posedge clk);
      #1;
      chk({tag, ".q"}, result, exp_q);
      chk({tag, ".r"}, odd, exp_r);
      chk({tag, ".v"}, {31'd0, out_valid}, 32'd1);
   endtask

   task automatic idle_cycle;
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] ra;
      logic [15:0] rb;

      rst_n    = 1'b0;
      in_valid = 1'b1;
      A        = 32'd100;
      B        = 16'd7;

      // Reset held: the clock toggles with a valid request, and nothing is captured.
      repeat (3) @(posedge clk);
      #1;
      chk("rst.q", result, 32'd0);
      chk("rst.r", odd, 32'd0);
      chk("rst.v", {31'd0, out_valid}, 32'd0);

      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b0;

      // Basic operation, followed by an idle cycle that holds the results.
      div_op("basic", 32'd100, 16'd7, 32'd14, 32'd2);
      idle_cycle();
      chk("hold.q", result, 32'd14);
      chk("hold.r", odd, 32'd2);
      chk("hold.v", {31'd0, out_valid}, 32'd0);

      // Extreme and boundary operand values.
      div_op("maxmax", 32'hFFFF_FFFF, 16'hFFFF, 32'h0001_0001, 32'd0);
      div_op("div1",   32'hFFFF_FFFF, 16'd1,    32'hFFFF_FFFF, 32'd0);
      div_op("altb",   32'd5,         16'd9,    32'd0,         32'd5);
      div_op("div0",   32'h1234_5678, 16'd0,    32'hFFFF_FFFF, 32'h1234_5678);
      div_op("div0max",32'hFFFF_FFFF, 16'd0,    32'hFFFF_FFFF, 32'hFFFF_FFFF);
      div_op("remmax", 32'd131070,    16'hFFFF, 32'd2,         32'd0);
      div_op("remtop", 32'd131069,    16'hFFFF, 32'd1,         32'd65534);

      // Back-to-back captures, with in_valid held high across three edges.
      div_op("b2b0", 32'd1000,  16'd10,  32'd100, 32'd0);
      div_op("b2b1", 32'd1001,  16'd10,  32'd100, 32'd1);
      div_op("b2b2", 32'd65535, 16'd256, 32'd255, 32'd255);
      idle_cycle();
      chk("b2b.end.v", {31'd0, out_valid}, 32'd0);

      // Asynchronous reset applied mid-cycle clears the outputs with no clock edge.
      div_op("pre_rst", 32'd100, 16'd7, 32'd14, 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst.q", result, 32'd0);
      chk("arst.r", odd, 32'd0);
      chk("arst.v", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b0;

      // Random vectors, applied one per cycle.
      for (int i = 0; i < 120; i++) begin
         ra = $urandom;
         rb = 16'($urandom_range(65535, 1));
         div_op("rand", ra, rb, ra / {16'd0, rb}, ra % {16'd0, rb});
      end
      idle_cycle();
      chk("final.v", {31'd0, out_valid}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
